// File: rtl/pipe_stall_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_stall_ctrl
// Stall/flush scheduler for the 5-stage core. Merges the ID load-use stall,
// EX multi-cycle operations (div, madd) and flush requests into a per-stage
// hold vector {wb,mem,ex,id,if,pc} and a flush strobe. The multi-cycle
// countdown lives here so EX and ID need no counters of their own.
//
// Optional feature macro: STALL_STATS_EN
//   defined   : stat_id_o / stat_mc_o count ID-stall and EX-stall cycles,
//               saturating at all-ones, cleared by rst.
//   undefined : no counters are built; stat_id_o / stat_mc_o are tied to 0.
//
// Handshake: there is no valid/ready pair on this block. Every request input
// is sampled as a level in the cycle it is presented. The outputs are a
// combinational function of the registered state, cnt and the current inputs,
// so a consumer sees the answer in the same cycle as the request.
// ----------------------------------------------------------------------------
module pipe_stall_ctrl #(
   parameter int MC_CNT_W = 6,
   parameter int STAT_W   = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stallreq_id_i,
   input  logic                mc_start_i,
   input  logic [MC_CNT_W-1:0] mc_cycles_i,
   input  logic                mc_cancel_i,
   input  logic                flush_i,
   output logic [5:0]          stall_o,
   output logic                flush_o,
   output logic                mc_busy_o,
   output logic                mc_done_o,
   output logic [STAT_W-1:0]   stat_id_o,
   output logic [STAT_W-1:0]   stat_mc_o
);

   // Hold-vector encodings, bit order {wb,mem,ex,id,if,pc}
   localparam logic [5:0] STALL_NONE = 6'b000000;
   localparam logic [5:0] STALL_ID   = 6'b000111;
   localparam logic [5:0] STALL_EX   = 6'b001111;

   localparam logic [MC_CNT_W-1:0] CNT_ZERO = '0;
   localparam logic [MC_CNT_W-1:0] CNT_ONE  = {{(MC_CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MC_BUSY = 2'd1,
      ST_FLUSH   = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [MC_CNT_W-1:0] cnt_q, cnt_d;

   // Ungated decisions; the reset gating is applied at the ports
   logic [5:0] stall_c;
   logic       flush_c;
   logic       busy_c;
   logic       done_c;

   // Next-state and output decode. Priority within a cycle:
   // flush_i > mc_cancel_i > running multi-cycle op > mc_start_i > stallreq_id_i
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stall_c = STALL_NONE;
      flush_c = 1'b0;
      busy_c  = 1'b0;
      done_c  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (flush_i) begin
               flush_c = 1'b1;
               state_d = ST_FLUSH;
            end else if (mc_start_i && (mc_cycles_i != CNT_ZERO)) begin
               // The start cycle itself is the first of the N stall cycles
               stall_c = STALL_EX;
               if (mc_cycles_i == CNT_ONE) begin
                  done_c = 1'b1;
               end else begin
                  cnt_d   = mc_cycles_i - CNT_ONE;
                  state_d = ST_MC_BUSY;
               end
            end else if (stallreq_id_i) begin
               // mc_cancel_i has nothing to abort here and is ignored
               stall_c = STALL_ID;
            end
         end
         ST_MC_BUSY: begin
            busy_c = 1'b1;
            if (flush_i) begin
               flush_c = 1'b1;
               cnt_d   = CNT_ZERO;
               state_d = ST_FLUSH;
            end else if (mc_cancel_i) begin
               stall_c = stallreq_id_i ? STALL_ID : STALL_NONE;
               cnt_d   = CNT_ZERO;
               state_d = ST_IDLE;
            end else begin
               // EX is held, so a new mc_start_i cannot be issued; the EX
               // hold also covers any ID load-use request
               stall_c = STALL_EX;
               cnt_d   = cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) begin
                  done_c  = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end
         ST_FLUSH: begin
            // Second flush cycle; every request is dropped, including flush_i
            flush_c = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
         end
      endcase
   end

   // State and countdown registers, asynchronously cleared
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= CNT_ZERO;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Outputs are held at zero for as long as reset is asserted
   always_comb begin
      stall_o   = rst ? STALL_NONE : stall_c;
      flush_o   = rst ? 1'b0 : flush_c;
      mc_busy_o = rst ? 1'b0 : busy_c;
      mc_done_o = rst ? 1'b0 : done_c;
   end

`ifdef STALL_STATS_EN
   localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};
   localparam logic [STAT_W-1:0] STAT_MAX = '1;

   logic [STAT_W-1:0] stat_id_q, stat_id_d;
   logic [STAT_W-1:0] stat_mc_q, stat_mc_d;

   // Saturating increment of the cycle counters on the emitted hold code
   always_comb begin
      stat_id_d = stat_id_q;
      stat_mc_d = stat_mc_q;
      if ((stall_o == STALL_ID) && (stat_id_q != STAT_MAX)) begin
         stat_id_d = stat_id_q + STAT_ONE;
      end
      if ((stall_o == STALL_EX) && (stat_mc_q != STAT_MAX)) begin
         stat_mc_d = stat_mc_q + STAT_ONE;
      end
   end

   // Statistics registers, cleared by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_id_q <= '0;
         stat_mc_q <= '0;
      end else begin
         stat_id_q <= stat_id_d;
         stat_mc_q <= stat_mc_d;
      end
   end

   assign stat_id_o = stat_id_q;
   assign stat_mc_o = stat_mc_q;
`else
   assign stat_id_o = '0;
   assign stat_mc_o = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipe_stall_ctrl
// Directed bench for pipe_stall_ctrl. Inputs change 1 time unit after each
// rising edge; outputs are sampled on the falling edge, where they reflect the
// current state and the inputs of that cycle. Expected values are written out
// by hand for each step. Honours STALL_STATS_EN for the counter expectations.
// ----------------------------------------------------------------------------
module tb_pipe_stall_ctrl;

   localparam int MC_CNT_W = 6;
   localparam int STAT_W   = 32;

   logic                clk;
   logic                rst;
   logic                stallreq_id_i;
   logic                mc_start_i;
   logic [MC_CNT_W-1:0] mc_cycles_i;
   logic                mc_cancel_i;
   logic                flush_i;
   logic [5:0]          stall_o;
   logic                flush_o;
   logic                mc_busy_o;
   logic                mc_done_o;
   logic [STAT_W-1:0]   stat_id_o;
   logic [STAT_W-1:0]   stat_mc_o;

   int tests_run;
   int tests_failed;

   // expected statistic values for the build in use
   logic [STAT_W-1:0] exp_stat_id;
   logic [STAT_W-1:0] exp_stat_mc;

   pipe_stall_ctrl #(
      .MC_CNT_W (MC_CNT_W),
      .STAT_W   (STAT_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .stallreq_id_i (stallreq_id_i),
      .mc_start_i    (mc_start_i),
      .mc_cycles_i   (mc_cycles_i),
      .mc_cancel_i   (mc_cancel_i),
      .flush_i       (flush_i),
      .stall_o       (stall_o),
      .flush_o       (flush_o),
      .mc_busy_o     (mc_busy_o),
      .mc_done_o     (mc_done_o),
      .stat_id_o     (stat_id_o),
      .stat_mc_o     (stat_mc_o)
   );

   // clock: period 10, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // one comparison point
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // all four control outputs in one go
   task automatic chk_out(input string tag, input logic [5:0] s, input logic f,
                          input logic b, input logic d);
      chk({tag, ".stall"}, {26'd0, stall_o}, {26'd0, s});
      chk({tag, ".flush"}, {31'd0, flush_o}, {31'd0, f});
      chk({tag, ".busy"},  {31'd0, mc_busy_o}, {31'd0, b});
      chk({tag, ".done"},  {31'd0, mc_done_o}, {31'd0, d});
   endtask

   task automatic drive(input logic id, input logic start, input logic [MC_CNT_W-1:0] n,
                        input logic cancel, input logic flush);
      stallreq_id_i = id;
      mc_start_i    = start;
      mc_cycles_i   = n;
      mc_cancel_i   = cancel;
      flush_i       = flush;
   endtask

   task automatic to_sample();
      @(negedge clk);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst = 1'b1;
      drive(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);

      // ---- reset state, with requests present while rst is high ----
      #2;
      drive(1'b1, 1'b1, 6'd4, 1'b0, 1'b1);
      #1;
      chk_out("rst_hold", 6'b000000, 1'b0, 1'b0, 1'b0);
      chk("rst_stat_id", stat_id_o, 32'd0);
      chk("rst_stat_mc", stat_mc_o, 32'd0);
      drive(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
      next_cycle();
      rst = 1'b0;
      to_sample();
      chk_out("idle", 6'b000000, 1'b0, 1'b0, 1'b0);
      next_cycle();

      // ---- ID load-use stall for two cycles ----
      drive(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
      to_sample(); chk_out("id_c1", 6'b000111, 1'b0, 1'b0, 1'b0);
      next_cycle();
      to_sample(); chk_out("id_c2", 6'b000111, 1'b0, 1'b0, 1'b0);
      next_cycle();
      drive(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
      to_sample(); chk_out("id_c3", 6'b000000, 1'b0, 1'b0, 1'b0);
`ifdef STALL_STATS_EN
      exp_stat_id = 32'd2;
`else
      exp_stat_id = 32'd0;
`endif
      chk("stat_id_after_t1", stat_id_o, exp_stat_id);
      next_cycle();

      // ---- multi-cycle op N=4, ID request raised mid-op is subsumed ----
      drive(1'b0, 1'b1, 6'd4, 1'b0, 1'b0);
      to_sample(); chk_out("mc4_c1", 6'b001111, 1'b0, 1'b0, 1'b0);
      next_cycle();
      drive(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
      to_sample(); chk_out("mc4_c2", 6'b001111, 1'b0, 1'b1, 1'b0);
      next_cycle();
      drive(1'b1, 1'b1, 6'd9, 1'b0, 1'b0);  // start ignored, ID subsumed
      to_sample(); chk_out("mc4_c3", 6'b001111, 1'b0, 1'b1, 1'b0);
      next_cycle();
      drive(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
      to_sample(); chk_out("mc4_c4", 6'b001111, 1'b0, 1'b1, 1'b1);
      next_cycle();
      to_sample(); chk_out("mc4_c5", 6'b000000, 1'b0, 1'b0, 1'b0);
`ifdef STALL_STATS_EN
      exp_stat_mc = 32'd4;
`else
      exp_stat_mc = 32'd0;
`endif
      chk("stat_id_after_t2", stat_id_o, exp_stat_id);
      chk("stat_mc_after_t2", stat_mc_o, exp_stat_mc);
      next_cycle();

      // ---- N=1: single stall cycle with done, never busy ----
      drive(1'b0, 1'b1, 6'd1, 1'b0, 1'b0);
      to_sample(); chk_out("mc1_c1", 6'b001111, 1'b0, 1'b0, 1'b1);
      next_cycle();
      drive(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
      to_sample(); chk_out("mc1_c2", 6'b000000, 1'b0, 1'b0, 1'b0);
      next_cycle();

      // ---- N=0: ignored ----
      drive(1'b0, 1'b1, 6'd0, 1'b0, 1'b0);
      to_sample(); chk_out("mc0_c1", 6'b000000, 1'b0, 1'b0, 1'b0);
      next_cycle();
      drive(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
      to_sample(); chk_out("mc0_c2", 6'b000000, 1'b0, 1'b0, 1'b0);
      next_cycle();

      // ---- cancel in IDLE is a no-op; ID still wins ----
      drive(1'b1, 1'b0, 6'd0, 1'b1, 1'b0);
      to_sample(); chk_out("cancel_idle", 6'b000111, 1'b0, 1'b0, 1'b0);
      next_cycle();

      // ---- cancel mid-op with ID request ----
      drive(1'b0, 1'b1, 6'd5, 1'b0, 1'b0);
      to_sample(); chk_out("cxl_c1", 6'b001111, 1'b0, 1'b0, 1'b0);
      next_cycle();
      drive(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
      to_sample(); chk_out("cxl_c2", 6'b001111, 1'b0, 1'b1, 1'b0);
      next_cycle();
      drive(1'b1, 1'b0, 6'd0, 1'b1, 1'b0);
      to_sample(); chk_out("cxl_c3", 6'b000111, 1'b0, 1'b1, 1'b0);
      next_cycle();
      drive(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
      to_sample(); chk_out("cxl_c4", 6'b000000, 1'b0, 1'b0, 1'b0);
      next_cycle();

      // ---- flush during the op; second flush in FLUSH does not extend ----
      drive(1'b0, 1'b1, 6'd4, 1'b0, 1'b0);
      to_sample(); chk_out("fl_c1", 6'b001111, 1'b0, 1'b0, 1'b0);
      next_cycle();
      drive(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
      to_sample(); chk_out("fl_c2", 6'b001111, 1'b0, 1'b1, 1'b0);
      next_cycle();
      drive(1'b1, 1'b0, 6'd0, 1'b1, 1'b1);  // flush beats cancel
      to_sample(); chk_out("fl_c3", 6'b000000, 1'b1, 1'b1, 1'b0);
      next_cycle();
      drive(1'b1, 1'b1, 6'd3, 1'b0, 1'b1);  // all ignored in FLUSH
      to_sample(); chk_out("fl_c4", 6'b000000, 1'b1, 1'b0, 1'b0);
      next_cycle();
      drive(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
      to_sample(); chk_out("fl_c5", 6'b000000, 1'b0, 1'b0, 1'b0);
      next_cycle();

      // ---- flush from IDLE beats a simultaneous start ----
      drive(1'b0, 1'b1, 6'd3, 1'b0, 1'b1);
      to_sample(); chk_out("fli_c1", 6'b000000, 1'b1, 1'b0, 1'b0);
      next_cycle();
      drive(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
      to_sample(); chk_out("fli_c2", 6'b000000, 1'b1, 1'b0, 1'b0);
      next_cycle();
      to_sample(); chk_out("fli_c3", 6'b000000, 1'b0, 1'b0, 1'b0);
      next_cycle();

      // ---- asynchronous reset pulse between edges while busy ----
      drive(1'b0, 1'b1, 6'd6, 1'b0, 1'b0);
      to_sample(); chk_out("ar_c1", 6'b001111, 1'b0, 1'b0, 1'b0);
      next_cycle();
      drive(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
      to_sample(); chk_out("ar_c2", 6'b001111, 1'b0, 1'b1, 1'b0);
      rst = 1'b1;
      #1;
      chk_out("ar_during", 6'b000000, 1'b0, 1'b0, 1'b0);
      chk("ar_stat_id", stat_id_o, 32'd0);
      chk("ar_stat_mc", stat_mc_o, 32'd0);
      #1;
      rst = 1'b0;
      #1;
      chk_out("ar_release", 6'b000000, 1'b0, 1'b0, 1'b0);
      next_cycle();
      to_sample(); chk_out("ar_after", 6'b000000, 1'b0, 1'b0, 1'b0);
      next_cycle();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
